// File: rtl/cpu_pkg.sv
// Shared CPU definitions for hazard detection: default geometry, the
// forwarding-select encoding and the scoreboard entry record.
package cpu_pkg;

    localparam int CPU_AW       = 5;
    localparam int CPU_DEPTH    = 3;
    localparam int CPU_LOAD_LAT = 1;
    localparam int CPU_CW       = 16;

    // Destination numbers are stored zero-extended to this width (AW <= RD_MAX).
    localparam int RD_MAX       = 8;

    // Forward select 0 reads the register file; k reads scoreboard entry k-1.
    localparam int FWD_RF       = 0;

    typedef struct packed {
        logic              v;
        logic              wreg;
        logic              load;
        logic [RD_MAX-1:0] rd;
    } sb_entry_t;

    // Forward-select code that picks the result held in scoreboard entry k.
    function automatic int fwd_of_stage(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_unit_p_if.sv
// ID-stage hazard bus: the pipeline presents the decoded instruction and
// the redirect, the hazard unit answers with forwards, stall and flush.
interface hazard_unit_p_if import cpu_pkg::*; #(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = CPU_DEPTH,
    parameter int CW    = CPU_CW
) ();

    localparam int FW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wreg;
    logic [AW-1:0] id_rd;
    logic          id_load;
    logic          ex_redirect;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic          stall;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_rd, id_load, ex_redirect,
        input  fwd_a, fwd_b, stall, flush, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_rd, id_load, ex_redirect,
        output fwd_a, fwd_b, stall, flush, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Per-operand scoreboard search: finds the youngest producer of one source
// register and reports whether that producer is a load not yet forwardable.
module hazard_match import cpu_pkg::*; #(
    parameter int DEPTH    = CPU_DEPTH,
    parameter int LOAD_LAT = CPU_LOAD_LAT,
    parameter int FW       = $clog2(CPU_DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] sb,
    input  logic [RD_MAX-1:0]     src,
    input  logic                  use_src,
    output logic [FW-1:0]         idx,
    output logic                  unready
);

    logic [DEPTH-1:0] hit_s;

    // An entry produces this source if it is a live register write to it; r0 never matches.
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_s[k] = sb[k].v && sb[k].wreg && (sb[k].rd == src) &&
                       (src != {RD_MAX{1'b0}}) && use_src;
        end
    end

    // Scan oldest to youngest so the youngest hit overrides; only its load state matters.
    always_comb begin
        idx     = FW'(FWD_RF);
        unready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx     = hit_s[k] ? FW'(fwd_of_stage(k)) : idx;
            unready = hit_s[k] ? (sb[k].load && (k < LOAD_LAT)) : unready;
        end
    end

endmodule

// File: rtl/hazard_unit_p.sv
// Pipeline hazard unit: a shift-register scoreboard of in-flight writers
// drives operand forwarding, load-use stalls, redirect flushes and a
// saturating stall counter.
module hazard_unit_p import cpu_pkg::*; #(
    parameter int AW       = CPU_AW,
    parameter int DEPTH    = CPU_DEPTH,
    parameter int LOAD_LAT = CPU_LOAD_LAT,
    parameter int CW       = CPU_CW
) (
    input logic            Clk,
    input logic            Rst,
    hazard_unit_p_if.slave bus
);

    localparam int FW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] sb_r;
    logic [CW-1:0]         stall_cnt_r;
    logic [FW-1:0]         idx_a_s;
    logic [FW-1:0]         idx_b_s;
    logic                  unready_a_s;
    logic                  unready_b_s;
    logic                  stall_s;
    logic                  flush_s;
    sb_entry_t             id_entry_s;

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FW       (FW)
    ) u_match_a (
        .sb      (sb_r),
        .src     (RD_MAX'(bus.id_rs)),
        .use_src (bus.id_use_rs),
        .idx     (idx_a_s),
        .unready (unready_a_s)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FW       (FW)
    ) u_match_b (
        .sb      (sb_r),
        .src     (RD_MAX'(bus.id_rt)),
        .use_src (bus.id_use_rt),
        .idx     (idx_b_s),
        .unready (unready_b_s)
    );

    // Raw hazard decisions; a redirect squashes ID, so it always beats a stall.
    always_comb begin
        flush_s = bus.ex_redirect;
        if (bus.id_valid && !bus.ex_redirect) begin
            stall_s = unready_a_s || unready_b_s;
        end else begin
            stall_s = 1'b0;
        end
        id_entry_s = '{v:    bus.id_valid,
                       wreg: bus.id_wreg,
                       load: bus.id_load,
                       rd:   RD_MAX'(bus.id_rd)};
    end

    // Outputs are held low while reset is asserted, whatever the inputs say.
    always_comb begin
        if (Rst) begin
            bus.fwd_a = FW'(FWD_RF);
            bus.fwd_b = FW'(FWD_RF);
            bus.stall = 1'b0;
            bus.flush = 1'b0;
        end else begin
            bus.fwd_a = idx_a_s;
            bus.fwd_b = idx_b_s;
            bus.stall = stall_s;
            bus.flush = flush_s;
        end
    end

    // Scoreboard advances every edge; a stalled or squashed ID enters as a bubble.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sb_r <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_r[k] <= sb_r[k-1];
            end
            sb_r[0] <= (stall_s || flush_s) ? '0 : id_entry_s;
        end
    end

    // Count stall cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CW'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: four parameterisations share one stimulus
// stream; a scoreboard-history model checks every output each cycle,
// and directed scenarios pin literal values.
module tb_hazard_unit_p;

    localparam int NC = 4;

    function automatic int dep_of(input int c);
        case (c)
            0:       return 3;
            1:       return 4;
            2:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic int ll_of(input int c);
        case (c)
            0:       return 1;
            1:       return 2;
            2:       return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int cw_of(input int c);
        case (c)
            2:       return 2;
            default: return 16;
        endcase
    endfunction

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_load, ex_redirect;
    logic [4:0] id_rs, id_rt, id_rd;

    logic [NC-1:0]       act_stall, act_flush;
    logic [NC-1:0][7:0]  act_fa, act_fb;
    logic [NC-1:0][15:0] act_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit run = 1'b0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        hazard_unit_p_if #(.AW(5), .DEPTH(dep_of(g)), .CW(cw_of(g))) bus ();

        hazard_unit_p #(
            .AW       (5),
            .DEPTH    (dep_of(g)),
            .LOAD_LAT (ll_of(g)),
            .CW       (cw_of(g))
        ) dut (
            .Clk (Clk),
            .Rst (Rst),
            .bus (bus)
        );

        assign bus.id_valid    = id_valid;
        assign bus.id_rs       = id_rs;
        assign bus.id_rt       = id_rt;
        assign bus.id_use_rs   = id_use_rs;
        assign bus.id_use_rt   = id_use_rt;
        assign bus.id_wreg     = id_wreg;
        assign bus.id_rd       = id_rd;
        assign bus.id_load     = id_load;
        assign bus.ex_redirect = ex_redirect;
        assign act_fa[g]       = 8'(bus.fwd_a);
        assign act_fb[g]       = 8'(bus.fwd_b);
        assign act_stall[g]    = bus.stall;
        assign act_flush[g]    = bus.flush;
        assign act_cnt[g]      = 16'(bus.stall_cnt);
    end

    // Model: history of what entered EX on each past edge (index 0 = most recent).
    bit m_v  [NC][8];
    bit m_w  [NC][8];
    bit m_l  [NC][8];
    int m_rd [NC][8];
    int m_cnt[NC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_outputs(input int c, output int fa, output int fb,
                                 output bit st, output bit fl);
        int ka, kb;
        bit hz;
        ka = -1;
        kb = -1;
        for (int k = 0; k < dep_of(c); k++) begin
            if (ka < 0 && m_v[c][k] && m_w[c][k] && m_rd[c][k] == int'(id_rs) &&
                id_rs != 5'd0 && id_use_rs) ka = k;
            if (kb < 0 && m_v[c][k] && m_w[c][k] && m_rd[c][k] == int'(id_rt) &&
                id_rt != 5'd0 && id_use_rt) kb = k;
        end
        hz = (ka >= 0 && m_l[c][ka] && ka < ll_of(c)) ||
             (kb >= 0 && m_l[c][kb] && kb < ll_of(c));
        fa = Rst ? 0 : ka + 1;
        fb = Rst ? 0 : kb + 1;
        st = !Rst && id_valid && !ex_redirect && hz;
        fl = !Rst && ex_redirect;
    endtask

    int efa, efb;
    bit est, efl;

    // Compare every configuration against the model, then advance the model one edge.
    always @(negedge Clk) begin
        if (run) begin
            for (int c = 0; c < NC; c++) begin
                model_outputs(c, efa, efb, est, efl);
                chk($sformatf("cfg%0d fwd_a", c), act_fa[c], efa);
                chk($sformatf("cfg%0d fwd_b", c), act_fb[c], efb);
                chk($sformatf("cfg%0d stall", c), act_stall[c], est);
                chk($sformatf("cfg%0d flush", c), act_flush[c], efl);
                chk($sformatf("cfg%0d stall_cnt", c), act_cnt[c], m_cnt[c]);
                if (Rst) begin
                    m_cnt[c] = 0;
                    for (int k = 0; k < 8; k++) begin
                        m_v[c][k] = 0; m_w[c][k] = 0; m_l[c][k] = 0; m_rd[c][k] = 0;
                    end
                end else begin
                    if (est && m_cnt[c] < (1 << cw_of(c)) - 1) m_cnt[c]++;
                    for (int k = dep_of(c) - 1; k >= 1; k--) begin
                        m_v[c][k] = m_v[c][k-1]; m_w[c][k] = m_w[c][k-1];
                        m_l[c][k] = m_l[c][k-1]; m_rd[c][k] = m_rd[c][k-1];
                    end
                    if (est || efl) begin
                        m_v[c][0] = 0; m_w[c][0] = 0; m_l[c][0] = 0; m_rd[c][0] = 0;
                    end else begin
                        m_v[c][0] = id_valid; m_w[c][0] = id_wreg;
                        m_l[c][0] = id_load;  m_rd[c][0] = int'(id_rd);
                    end
                end
            end
        end
    end

    task automatic set_id(input bit v, input bit w, input bit ld, input int rd,
                          input int rs, input bit urs, input int rt, input bit urt,
                          input bit redir);
        id_valid = v;  id_wreg = w;    id_load = ld;   id_rd = 5'(rd);
        id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
        ex_redirect = redir;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge Clk);
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        Rst = 1'b1;
        tick();
        run = 1'b1;
        tick();
        Rst = 1'b0;

        // Reset state
        at_neg();
        chk("reset fwd_a", act_fa[0], 0);
        chk("reset stall", act_stall[0], 0);
        chk("reset stall_cnt", act_cnt[0], 0);
        tick();

        // add r3 in EX, ID reads r3
        set_id(1, 1, 0, 3, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 3, 1, 0, 0, 0);
        at_neg();
        chk("add fwd_a", act_fa[0], 1);
        chk("add stall", act_stall[0], 0);
        tick();

        // lw r5 in EX, ID reads rt=r5: one stall cycle, then forward from entry 1
        set_id(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 5, 1, 0);
        at_neg();
        chk("lw stall", act_stall[0], 1);
        chk("lw cnt before", act_cnt[0], 0);
        tick();
        at_neg();
        chk("lw fwd_b after", act_fb[0], 2);
        chk("lw stall after", act_stall[0], 0);
        chk("lw cnt after", act_cnt[0], 1);
        tick();

        // r7 producers in entries 0 and 2: youngest wins
        set_id(1, 1, 0, 7, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 7, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 7, 1, 0, 0, 0);
        at_neg();
        chk("youngest fwd_a", act_fa[0], 1);
        tick();
        // write to r0 in EX never forwards; r7 is now in entry 2
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 1, 7, 1, 0);
        at_neg();
        chk("r0 fwd_a", act_fa[0], 0);
        chk("r7 fwd_b entry2", act_fb[0], 3);
        tick();

        // lw r4 in EX with redirect: flush wins, entry 0 bubbles
        set_id(1, 1, 1, 4, 0, 0, 0, 0, 0); tick();
        set_id(1, 1, 0, 4, 4, 1, 0, 0, 1);
        at_neg();
        chk("redirect flush", act_flush[0], 1);
        chk("redirect stall", act_stall[0], 0);
        tick();
        set_id(1, 0, 0, 0, 4, 1, 0, 0, 0);
        at_neg();
        chk("post-flush fwd_a", act_fa[0], 2);
        chk("post-flush stall", act_stall[0], 0);
        tick();

        // DEPTH=4, LOAD_LAT=2: two stall cycles then forward from entry 2
        set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 9, 1, 0, 0, 0);
        at_neg();
        chk("ll2 stall c1", act_stall[1], 1);
        chk("ll0 stall", act_stall[3], 0);
        chk("ll0 fwd_a", act_fa[3], 1);
        tick();
        at_neg();
        chk("ll2 stall c2", act_stall[1], 1);
        tick();
        at_neg();
        chk("ll2 stall c3", act_stall[1], 0);
        chk("ll2 fwd_a", act_fa[1], 3);
        tick();

        // CW=2 saturation, then reset in the middle of a long stall
        Rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        Rst = 1'b0;
        set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 9, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("cw2 stalling", act_stall[2], 1);
            tick();
        end
        at_neg();
        chk("cw2 saturated", act_cnt[2], 3);
        chk("cw2 still stall", act_stall[2], 1);
        tick();
        Rst = 1'b1;
        ex_redirect = 1'b1;
        at_neg();
        chk("rst stall", act_stall[2], 0);
        chk("rst flush", act_flush[2], 0);
        chk("rst fwd_a", act_fa[2], 0);
        tick();
        Rst = 1'b0;
        ex_redirect = 1'b0;
        at_neg();
        chk("post-rst cnt", act_cnt[2], 0);
        chk("post-rst stall", act_stall[2], 0);
        tick();

        // Randomized traffic with occasional redirects and resets
        for (int i = 0; i < 800; i++) begin
            Rst = ($urandom_range(0, 49) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) == 0);
            tick();
        end
        Rst = 1'b0;
        at_neg();
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_p.md
HAZARD_UNIT_P -- requirements
Module: hazard_unit_p

Interface
REQ-001 Parameter AW, default 5, is the register-address width.
REQ-002 Parameter DEPTH, default 3, is the number of tracked stages beyond ID (EX, MEM, WB); legal range 1..7.
REQ-003 Parameter LOAD_LAT, default 1, is the minimum scoreboard index from which a load result is forwardable; legal range 0..DEPTH.
REQ-004 Parameter CW, default 16, is the stall-counter width.
REQ-005 The design SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register numbers.
- id_use_rs, id_use_rt  in  1  the source is actually read.
- id_wreg  in  1  the ID instruction writes a register.
- id_rd  in  AW  destination register number.
- id_load  in  1  the ID instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- fwd_a, fwd_b  out  FW=$clog2(DEPTH+1)  0 selects the register file; k selects the result of scoreboard entry k-1.
- stall  out  1  active-high; hold PC and IF/ID, inject a bubble.
- flush  out  1  squash IF/ID.
- stall_cnt  out  CW  saturating count of stall cycles.

Function
REQ-006 The scoreboard SHALL be a DEPTH-entry shift register of {v, wreg, load, rd}; entry 0 = EX, entry k = k stages past EX.
REQ-007 On every non-reset edge, entry k SHALL take entry k-1 (k≥1), and the oldest entry SHALL be discarded.
REQ-008 On every non-reset edge, entry 0 SHALL take {id_valid, id_wreg, id_load, id_rd} when stall=0 and flush=0, and SHALL take all-zero (bubble) otherwise.
REQ-009 An entry SHALL match source s when all of the following hold: v=1; wreg=1; rd==s; rd≠0; the matching use flag is 1.
REQ-010 fwd_a SHALL equal k+1 for the lowest-index entry k matching id_rs, and 0 if no entry matches; fwd_b SHALL be derived the same way for id_rt.
REQ-011 stall SHALL be 1 when id_valid=1, flush=0, and, for either source, the lowest-index matching entry k has load=1 and k<LOAD_LAT.
- An older non-load match SHALL NOT mask a younger unready load.
REQ-012 flush SHALL equal ex_redirect.
REQ-013 When flush=1, stall SHALL be 0 (redirect wins).
REQ-014 fwd_a, fwd_b, stall and flush SHALL be combinational from the scoreboard state and the current inputs, with zero-cycle latency; the scoreboard SHALL be registered.
REQ-015 While stall=1 the ID inputs SHALL be held by the pipeline, and the stall SHALL self-clear after LOAD_LAT-k cycles as the load advances.
REQ-016 stall_cnt SHALL increment on each edge where stall=1, SHALL saturate at all-ones, and SHALL never wrap.
REQ-017 When LOAD_LAT=0, stall SHALL be constant 0.
REQ-018 Register 0 SHALL never produce a forward or a stall.

Reset
REQ-019 While Rst=1, the edge SHALL clear every scoreboard entry to zero and clear stall_cnt to 0.
REQ-020 While Rst=1, fwd_a, fwd_b, stall and flush SHALL be forced to 0 regardless of the other inputs.
REQ-021 A reset arriving mid-stall SHALL discard the pending load.
- The first post-reset cycle SHALL stall only on new scoreboard contents.

Structure
REQ-022 The fwd-select encodings (FWD_RF=0 and stage-index meaning), the scoreboard-entry record type and the default parameter values SHALL live in a shared package, cpu_pkg.
REQ-023 One sub-module, hazard_match, SHALL be instantiated per source operand.
- It takes the scoreboard and a source number, and returns the youngest-match index and an unready-load flag.

Verification
REQ-024 Default parameters; add r3 in EX, ID reads rs=3 -> fwd_a=1, stall=0.
REQ-025 lw r5 in EX, ID reads rt=5 -> stall=1 for one cycle, and entry 0 becomes a bubble. On the next cycle fwd_b=2, stall=0, and stall_cnt has incremented by 1.
REQ-026 Matching producers for r7 in entries 0 and 2 -> fwd_a=1 (youngest wins). With a write to r0 in EX and ID reading r0 -> fwd_a=0.
REQ-027 lw r4 in EX with ex_redirect=1 and ID reading r4 -> flush=1, stall=0, and entry 0 becomes a bubble on the next edge.
REQ-028 DEPTH=4, LOAD_LAT=2, lw r9 in EX, ID reads r9 -> stall=1 for 2 cycles, then fwd=3.
REQ-029 CW=2 with 5 consecutive stalls -> stall_cnt stays at 3. Asserting Rst mid-stall -> all outputs 0 on that cycle and stall_cnt=0 after the edge.
